// File: rtl/mar_loader_if.sv
// ---------------------------------------------------------------------------
// mar_loader_if
// Signal bundle between the memory-address-register / program loader and its
// neighbours (control unit, program source, 16x8 RAM).
//   control unit -> loader : mi, oa_ctl, wa_ctl, cs_ctl
//   program src  -> loader : prog, din, din_valid
//   loader -> program src  : din_ready, done, cksum
//   loader -> RAM          : addr, ram_oa, ram_wa, ram_cs
// The tristate system bus stays a plain inout port on the loader itself.
// Modports: master = control unit / program source side, slave = loader.
// ---------------------------------------------------------------------------
interface mar_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              mi;
    logic              oa_ctl;
    logic              wa_ctl;
    logic              cs_ctl;
    logic              prog;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [ADDR_W-1:0] addr;
    logic              ram_oa;
    logic              ram_wa;
    logic              ram_cs;
    logic              done;
    logic [DATA_W-1:0] cksum;

    modport master (
        output mi, oa_ctl, wa_ctl, cs_ctl, prog, din, din_valid,
        input  din_ready, addr, ram_oa, ram_wa, ram_cs, done, cksum
    );

    modport slave (
        input  mi, oa_ctl, wa_ctl, cs_ctl, prog, din, din_valid,
        output din_ready, addr, ram_oa, ram_wa, ram_cs, done, cksum
    );
endinterface

// File: rtl/mar_loader.sv
// ---------------------------------------------------------------------------
// mar_loader
// Memory address register plus program loader sitting in front of the 16x8
// RAM.
//   Run mode    : MAR loads from bus[ADDR_W-1:0] on mi; control-unit strobes
//                 pass straight through to the RAM.
//   Program mode: bytes arrive over din/din_valid/din_ready and are written
//                 to RAM addresses 0..DEPTH-1 in order; the loader drives the
//                 bus, addr and the RAM strobes itself.
// Ports:
//   clk  - system clock, all state changes on posedge
//   clr  - asynchronous active-high reset
//   bus  - shared system bus, driven only while a program byte is written
//   bif  - mar_loader_if.slave (control strobes, program handshake, RAM side)
// Optional build macro LOADER_CKSUM_EN: when defined, cksum is the modulo-256
// sum of every byte accepted since program mode was entered; otherwise cksum
// is tied to zero.
// ---------------------------------------------------------------------------
module mar_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    inout  wire  [DATA_W-1:0] bus,
    mar_loader_if.slave       bif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PWAIT = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q,   mar_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic [DATA_W-1:0] dat_q,   dat_d;
    logic              done_q,  rdy_q;

    logic [ADDR_W-1:0] addr_o;
    logic              oa_o, wa_o, cs_o, drive_o;
    logic              accept;

    // Only the low nibble of the bus addresses the RAM; the upper bits are
    // deliberately ignored when loading the MAR.
    logic              unused_bus_hi;
    assign unused_bus_hi = ^bus[DATA_W-1:ADDR_W];

    // State register and registered handshake/status flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_RUN;
            mar_q   <= '0;
            ptr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            ptr_q   <= ptr_d;
            dat_q   <= dat_d;
            // Flags track the state being entered so they are valid for the
            // whole of that state.
            done_q  <= (state_d == S_DONE);
            rdy_q   <= (state_d == S_PWAIT);
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        ptr_d   = ptr_q;
        dat_d   = dat_q;
        accept  = 1'b0;
        addr_o  = mar_q;
        oa_o    = 1'b0;
        wa_o    = 1'b0;
        cs_o    = 1'b0;
        drive_o = 1'b0;

        case (state_q)
            S_RUN: begin
                addr_o = mar_q;
                oa_o   = bif.oa_ctl;
                wa_o   = bif.wa_ctl;
                cs_o   = bif.cs_ctl;
                if (bif.mi) begin
                    mar_d = bus[ADDR_W-1:0];
                end
                if (bif.prog) begin
                    state_d = S_PWAIT;
                    ptr_d   = '0;
                end
            end
            S_PWAIT: begin
                addr_o = ptr_q;
                // Dropping prog wins over a byte offered in the same cycle.
                if (!bif.prog) begin
                    state_d = S_RUN;
                end else if (bif.din_valid && rdy_q) begin
                    accept  = 1'b1;
                    dat_d   = bif.din;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // One-cycle write; prog is not looked at until it completes.
                addr_o  = ptr_q;
                cs_o    = 1'b1;
                wa_o    = 1'b1;
                drive_o = 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    ptr_d   = '0;
                    state_d = S_DONE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = S_PWAIT;
                end
            end
            S_DONE: begin
                addr_o = '0;
                if (!bif.prog) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign bus           = drive_o ? dat_q : {DATA_W{1'bz}};
    assign bif.addr      = addr_o;
    assign bif.ram_oa    = oa_o;
    assign bif.ram_wa    = wa_o;
    assign bif.ram_cs    = cs_o;
    assign bif.din_ready = rdy_q;
    assign bif.done      = done_q;

`ifdef LOADER_CKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Cleared on entry to program mode, accumulates accepted bytes, and
    // otherwise holds (through DONE and back in RUN).
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sum_q <= '0;
        end else if (state_q == S_RUN && bif.prog) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + bif.din;
        end
    end

    assign bif.cksum = sum_q;
`else
    assign bif.cksum = '0;
`endif

endmodule

// File: tb/tb_mar_loader.sv
// ---------------------------------------------------------------------------
// tb_mar_loader
// Random and directed stimulus for mar_loader, checked every cycle against a
// transaction-level reference model (program/write phase, byte count, RAM
// image, running sum) and against fixed expected values for the directed
// scenarios. A behavioural 16x8 RAM captures whatever the loader writes.
// ---------------------------------------------------------------------------
module tb_mar_loader;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    wire  [DW-1:0] bus;
    logic [DW-1:0] bus_drv;
    logic          bus_en;
    assign bus = bus_en ? bus_drv : {DW{1'bz}};

    mar_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

    mar_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus),
        .bif (bif)
    );

    // Behavioural RAM
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (bif.ram_cs && bif.ram_wa) ram[bif.addr] <= bus;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: program mode is "loading n bytes so far", with a
    // pending write between acceptance and the next byte slot.
    // ------------------------------------------------------------------
    bit            m_loading, m_wr, m_done, m_acc;
    logic [AW-1:0] m_mar;
    int            m_cnt;
    logic [DW-1:0] m_byte, m_sum;
    logic [DW-1:0] m_mem [16];
    int            edge_n = 0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_loading = 0; m_wr = 0; m_done = 0; m_acc = 0;
            m_mar = '0; m_cnt = 0; m_byte = '0; m_sum = '0;
        end else begin
            edge_n++;
            m_acc = 0;
            if (m_wr) begin
                m_mem[m_cnt] = m_byte;
                m_wr = 0;
                if (m_cnt == 15) begin
                    m_cnt  = 0;
                    m_done = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (m_done) begin
                if (!bif.prog) begin
                    m_done = 0; m_loading = 0;
                end
            end else if (m_loading) begin
                if (!bif.prog) begin
                    m_loading = 0;
                end else if (bif.din_valid) begin
                    m_byte = bif.din;
                    m_sum  = m_sum + bif.din;
                    m_wr   = 1;
                    m_acc  = 1;
                end
            end else begin
                if (bif.cs_ctl && bif.wa_ctl) m_mem[m_mar] = bus;
                if (bif.mi) m_mar = bus[AW-1:0];
                if (bif.prog) begin
                    m_loading = 1; m_cnt = 0; m_sum = '0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge
    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on && !clr) begin
            bit run;
            run = !m_loading && !m_done;
            chk("addr",      32'(bif.addr),   m_done ? 32'd0 : (m_loading ? 32'(m_cnt) : 32'(m_mar)));
            chk("ram_oa",    32'(bif.ram_oa), run ? 32'(bif.oa_ctl) : 32'd0);
            chk("ram_wa",    32'(bif.ram_wa), run ? 32'(bif.wa_ctl) : 32'(m_wr));
            chk("ram_cs",    32'(bif.ram_cs), run ? 32'(bif.cs_ctl) : 32'(m_wr));
            chk("din_ready", 32'(bif.din_ready), 32'(m_loading && !m_wr && !m_done));
            chk("done",      32'(bif.done),   32'(m_done));
`ifdef LOADER_CKSUM_EN
            chk("cksum",     32'(bif.cksum),  32'(m_sum));
`else
            chk("cksum",     32'(bif.cksum),  32'd0);
`endif
            if (m_wr) chk("bus_wr", 32'(bus), 32'(m_byte));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(negedge clk);
        #1;
        bus_en = !m_loading && !m_done;
    endtask

    task automatic run_ctl();
        bif.mi     = 1'($urandom_range(0, 1));
        bif.oa_ctl = 1'($urandom_range(0, 1));
        bif.wa_ctl = 1'($urandom_range(0, 1));
        bif.cs_ctl = 1'($urandom_range(0, 1));
        bus_drv    = 8'($urandom);
    endtask

    // Strobes during a load: random where ignored, quiet while still in RUN
    task automatic loose_ctl();
        bit run;
        run = !m_loading && !m_done;
        bif.mi     = run ? 1'b0 : 1'($urandom_range(0, 1));
        bif.wa_ctl = run ? 1'b0 : 1'($urandom_range(0, 1));
        bif.oa_ctl = 1'($urandom_range(0, 1));
        bif.cs_ctl = 1'($urandom_range(0, 1));
    endtask

    int acc_edge, done_edge;

    // seq: bytes 1,2,3..; bp: din_valid 1,0,0,1 then random;
    // stop_at < 0 runs to done, otherwise returns during the write of that address
    task automatic do_load(input bit seq, input bit bp, input int stop_at);
        int idx, guard, vpos;
        bit stop;
        logic [3:0] vpat;
        idx = 0; guard = 0; vpos = 0; stop = 0;
        vpat = 4'b1001;
        acc_edge = -1; done_edge = -1;
        bif.prog      = 1'b1;
        bif.din       = seq ? 8'd1 : 8'($urandom);
        bif.din_valid = 1'b1;
        while (!stop && guard < 300) begin
            cyc();
            guard++;
            if (m_acc) begin
                idx++;
                if (acc_edge < 0) acc_edge = edge_n;
                bif.din = seq ? 8'(idx + 1) : 8'($urandom);
            end
            if (bif.done && done_edge < 0) done_edge = edge_n;
            if (bp) begin
                bif.din_valid = (vpos < 4) ? vpat[3 - vpos] : 1'($urandom_range(0, 1));
                vpos++;
            end
            loose_ctl();
            stop = (stop_at < 0) ? m_done : (m_wr && m_cnt == stop_at);
        end
        chk("load_timeout", 32'(stop), 32'd1);
    endtask

    task automatic cmp_ram();
        for (int i = 0; i < 16; i++) chk($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(m_mem[i]));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [DW-1:0] b3;
        for (int i = 0; i < 16; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        bus_en = 1'b1; bus_drv = 8'h00;
        bif.mi = 0; bif.oa_ctl = 0; bif.wa_ctl = 0; bif.cs_ctl = 0;
        bif.prog = 0; bif.din = '0; bif.din_valid = 0;

        // Reset state
        #1 clr = 1'b1;
        #12;
        chk("rst_addr",  32'(bif.addr), 32'd0);
        chk("rst_done",  32'(bif.done), 32'd0);
        chk("rst_rdy",   32'(bif.din_ready), 32'd0);
        chk("rst_cs",    32'(bif.ram_cs), 32'd0);
        chk("rst_cksum", 32'(bif.cksum), 32'd0);
        @(negedge clk);
        #1 clr = 1'b0;
        chk_on = 1;

        // MAR load from the low nibble, then strobe pass-through
        bus_drv = 8'hA5; bif.mi = 1'b1;
        cyc();
        bif.mi = 1'b0;
        chk("mar_a5", 32'(bif.addr), 32'h5);
        bif.oa_ctl = 1'b1; bif.cs_ctl = 1'b1;
        #1;
        chk("pass_oa", 32'(bif.ram_oa), 32'd1);
        chk("pass_cs", 32'(bif.ram_cs), 32'd1);
        for (int i = 0; i < 12; i++) begin
            cyc();
            run_ctl();
        end
        cyc();
        bif.mi = 0; bif.wa_ctl = 0;

        // Full load of 01..10 with din_valid held high
        do_load(1'b1, 1'b0, -1);
        chk("done_latency", 32'(done_edge - acc_edge + 1), 32'd32);
        for (int i = 0; i < 16; i++) chk($sformatf("seq_ram[%0d]", i), 32'(ram[i]), 32'(i + 1));
`ifdef LOADER_CKSUM_EN
        chk("seq_cksum", 32'(bif.cksum), 32'h88);
`else
        chk("seq_cksum", 32'(bif.cksum), 32'h00);
`endif
        cyc();
        chk("done_held", 32'(bif.done), 32'd1);
        bif.prog = 0; bif.din_valid = 0;
        cyc(); cyc();

        // Random bytes with backpressure
        do_load(1'b0, 1'b1, -1);
        cmp_ram();
        bif.prog = 0; bif.din_valid = 0;
        cyc(); cyc();

        // Abort during the write to address 3
        bif.mi = 1'b1; bif.wa_ctl = 0; bus_drv = 8'h3C;
        cyc();
        bif.mi = 1'b0;
        chk("mar_pre", 32'(bif.addr), 32'hC);
        do_load(1'b0, 1'b0, 3);
        b3 = m_byte;
        bif.prog = 0; bif.din_valid = 0; bif.mi = 0; bif.wa_ctl = 0;
        cyc();
        chk("abort_rdy",  32'(bif.din_ready), 32'd1);
        chk("abort_ram3", 32'(ram[3]), 32'(b3));
        cyc();
        chk("abort_addr", 32'(bif.addr), 32'hC);
        chk("abort_done", 32'(bif.done), 32'd0);
        cyc();

        // Asynchronous reset in the middle of the write to address 7
        do_load(1'b0, 1'b0, 7);
        bif.prog = 0; bif.din_valid = 0; bif.mi = 0;
        bif.oa_ctl = 0; bif.wa_ctl = 0; bif.cs_ctl = 0;
        #1 clr = 1'b1;
        #1;
        chk("mid_rst_addr", 32'(bif.addr), 32'd0);
        chk("mid_rst_cs",   32'(bif.ram_cs), 32'd0);
        chk("mid_rst_wa",   32'(bif.ram_wa), 32'd0);
        chk("mid_rst_rdy",  32'(bif.din_ready), 32'd0);
        chk("mid_rst_done", 32'(bif.done), 32'd0);
        #1 clr = 1'b0;
        cyc();
        do_load(1'b0, 1'b1, -1);
        cmp_ram();
        bif.prog = 0; bif.din_valid = 0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
